// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_os #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  rx_i,
   input  logic                  ready_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  frame_err_o,
   output logic                  overrun_o,
   output logic                  parity_err_o
);

   localparam int TICK_DIV =
      (CLK_FREQ + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [TW-1:0] T_END  = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SC_MID = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] SC_END = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

   generate
      if (TICK_DIV < 1) begin : g_bad_div
         $error("uart_rx_os: TICK_DIV must be >= 1");
      end
      if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
         $error("uart_rx_os: OVERSAMPLE must be even and >= 4");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                state;
   logic                  rx_m;
   logic                  rx_s;
   logic                  rx_d;
   logic [TW-1:0]         tcnt;
   logic [SW-1:0]         sc;
   logic [BW-1:0]         bidx;
   logic [1:0]            hist;
   logic [DATA_WIDTH-1:0] shift;
   logic                  done;
   logic                  tick;
   logic                  fall;
   logic                  maj;
   logic                  perr;
   logic [SW-1:0]         sc_nxt;

   assign tick   = (tcnt == T_END);
   assign fall   = rx_d & ~rx_s;
   assign sc_nxt = (sc == SC_END) ? '0 : sc + SW'(1);
   // 2-of-3 vote over the two previous ticks and the current one
   assign maj    = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);

`ifdef UART_RX_PARITY_EN
   logic par_bit;
   logic par_err_q;

   assign perr         = ^{shift, par_bit};
   assign parity_err_o = par_err_q;
`else
   assign perr         = 1'b0;
   assign parity_err_o = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         rx_m        <= 1'b1;
         rx_s        <= 1'b1;
         rx_d        <= 1'b1;
         tcnt        <= '0;
         sc          <= '0;
         bidx        <= '0;
         hist        <= 2'b11;
         shift       <= '0;
         done        <= 1'b0;
         frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit     <= 1'b0;
         par_err_q   <= 1'b0;
`endif
      end else begin
         rx_m        <= rx_i;
         rx_s        <= rx_m;
         rx_d        <= rx_s;
         done        <= 1'b0;
         frame_err_o <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q   <= 1'b0;
`endif
         if ((state == IDLE && fall) || tick) begin
            tcnt <= '0;
         end else begin
            tcnt <= tcnt + TW'(1);
         end
         if (tick) begin
            hist <= {hist[0], rx_s};
         end
         unique case (state)
            IDLE: begin
               if (fall) begin
                  state <= START;
                  sc    <= '0;
                  bidx  <= '0;
               end
            end
            START: begin
               if (tick) begin
                  sc <= sc_nxt;
                  if (sc == SC_MID && maj) begin
                     state <= IDLE;
                  end else if (sc == SC_END) begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  sc <= sc_nxt;
                  if (sc == SC_MID) begin
                     shift <= {maj, shift[DATA_WIDTH-1:1]};
                  end
                  if (sc == SC_END) begin
                     bidx <= bidx + BW'(1);
                     if (bidx == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                     end
                  end
               end
            end
            PARITY: begin
               if (tick) begin
                  sc <= sc_nxt;
`ifdef UART_RX_PARITY_EN
                  if (sc == SC_MID) begin
                     par_bit <= maj;
                  end
`endif
                  if (sc == SC_END) begin
                     state <= STOP;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  sc <= sc_nxt;
                  // leave at mid-stop so the next start edge is not missed
                  if (sc == SC_MID) begin
                     state       <= IDLE;
                     frame_err_o <= ~maj;
                     done        <= maj & ~perr;
`ifdef UART_RX_PARITY_EN
                     par_err_q   <= perr;
`endif
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_o   <= 1'b0;
         data_o    <= '0;
         overrun_o <= 1'b0;
      end else begin
         overrun_o <= 1'b0;
         if (done) begin
            if (!valid_o || ready_i) begin
               data_o  <= shift;
               valid_o <= 1'b1;
            end else begin
               overrun_o <= 1'b1;
            end
         end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
         end
      end
   end

endmodule
